// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder controller. Latches two WIDTH-bit operands and
//            a carry-in on start, then drives one bit pair per cycle (LSB
//            first) into an external single-bit Full_Adder cell. Each sum bit
//            is collected and the carry is fed back through a flip-flop. The
//            completed result is registered and flagged by a one-cycle done.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, a, b, cin  - operation request and operands
//            fa_d1/fa_d2/fa_cin- bit pair and carry to the Full_Adder
//            fa_sum/fa_cout    - combinational results from the Full_Adder
//            busy, done        - RUN indicator, one-cycle completion pulse
//            sum, cout         - last completed result (registered)
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_d1,
  output logic             fa_d2,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  // Only the WIDTH-1 most recent sum bits need storage: the final bit comes
  // straight from fa_sum on the completing edge.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic             w_run;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum_next;

  assign w_run      = (state_q == S_RUN);
  // A new request is honoured only when no operation is in flight.
  assign w_accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_sum_next = {fa_sum, sum_sh_q};

  // Full_Adder inputs come from registers only, so they are stable all cycle.
  assign fa_d1  = w_run & a_sh_q[0];
  assign fa_d2  = w_run & b_sh_q[0];
  assign fa_cin = w_run & carry_q;

  assign busy = w_run;
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      S_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = w_sum_next[WIDTH-1:1];
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = w_sum_next;
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance from IDLE or DONE overrides the fall-back to IDLE above.
    if (w_accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl. Instantiates a WIDTH=8
//            and a WIDTH=2 controller, each closed around a behavioural
//            full adder, and drives directed vectors with hand-computed
//            results.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  // WIDTH = 8 instance
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       fa_d1, fa_d2, fa_cin, fa_sum, fa_cout;
  logic       busy, done, cout;
  logic [7:0] sum;

  // WIDTH = 2 instance
  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       fa2_d1, fa2_d2, fa2_cin, fa2_sum, fa2_cout;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  // Behavioural Full_Adder cells
  assign fa_sum   = fa_d1 ^ fa_d2 ^ fa_cin;
  assign fa_cout  = (fa_d1 & fa_d2) | (fa_cin & (fa_d1 ^ fa_d2));
  assign fa2_sum  = fa2_d1 ^ fa2_d2 ^ fa2_cin;
  assign fa2_cout = (fa2_d1 & fa2_d2) | (fa2_cin & (fa2_d1 ^ fa2_d2));

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .fa_d1(fa_d1), .fa_d2(fa_d2), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .fa_d1(fa2_d1), .fa_d2(fa2_d2), .fa_cin(fa2_cin),
    .fa_sum(fa2_sum), .fa_cout(fa2_cout),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete WIDTH=8 operation with a single-cycle start pulse.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [8:0] exp);
    logic c;
    c = cv;
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_run"}, done, 0);
      check({tag, "_fa_d1"}, fa_d1, av[i]);
      check({tag, "_fa_d2"}, fa_d2, bv[i]);
      check({tag, "_fa_cin"}, fa_cin, c);
      c = (av[i] & bv[i]) | (c & (av[i] ^ bv[i]));
      tick();
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_fa_idle"}, {fa_d1, fa_d2, fa_cin}, 0);
    check({tag, "_result"}, {cout, sum}, exp);
    tick();
    check({tag, "_done_after"}, done, 0);
    check({tag, "_hold"}, {cout, sum}, exp);
  endtask

  logic [7:0] ca [3];
  logic [7:0] cb [3];
  logic       cc [3];
  logic [8:0] ce [3];
  logic [4:0] vv;
  logic [2:0] exp2;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {cout, sum}, 0);
    check("rst_fa", {fa_d1, fa_d2, fa_cin}, 0);
    check("rst_w2", {busy2, done2, cout2, sum2}, 0);

    // Test 1: basic add, timing and Full_Adder drive
    run_op("t1", 8'h5A, 8'h3C, 1'b0, 9'h096);

    // Test 2: carry out of the top bit
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 9'h100);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Test 3: start during RUN is ignored
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_hold_prev", {cout, sum}, 9'h1FF);
    tick();
    tick();
    a = 8'hAA; start = 1'b1;
    check("t3_busy_mid", busy, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_busy", busy, 1);
      check("t3_done_run", done, 0);
      tick();
    end
    check("t3_done", done, 1);
    check("t3_result", {cout, sum}, 9'h033);
    tick();
    check("t3_no_extra_done", done, 0);
    check("t3_idle", busy, 0);
    tick();
    check("t3_no_extra_done2", done, 0);

    // Test 4: reset mid-RUN aborts and clears the result
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t4_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_result", {cout, sum}, 0);
    check("t4_fa", {fa_d1, fa_d2, fa_cin}, 0);
    run_op("t4b", 8'h01, 8'h01, 1'b0, 9'h002);

    // Test 5: start held high, back-to-back operations through DONE
    ca[0] = 8'h12; cb[0] = 8'h34; cc[0] = 1'b0; ce[0] = 9'h046;
    ca[1] = 8'h80; cb[1] = 8'h80; cc[1] = 1'b1; ce[1] = 9'h101;
    ca[2] = 8'hC3; cb[2] = 8'h3C; cc[2] = 1'b0; ce[2] = 9'h0FF;
    a = ca[0]; b = cb[0]; cin = cc[0]; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        check("t5_busy", busy, 1);
        check("t5_done_run", done, 0);
        tick();
      end
      check("t5_done", done, 1);
      check("t5_result", {cout, sum}, ce[k]);
      if (k < 2) begin
        a = ca[k+1]; b = cb[k+1]; cin = cc[k+1];
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("t5_idle_busy", busy, 0);
    check("t5_idle_done", done, 0);

    // Test 6: WIDTH=2 exhaustive
    for (int v = 0; v < 32; v++) begin
      vv = v[4:0];
      a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0]; start2 = 1'b1;
      exp2 = {1'b0, vv[4:3]} + {1'b0, vv[2:1]} + {2'b00, vv[0]};
      tick();
      start2 = 1'b0;
      tick();
      tick();
      check("t6_done", done2, 1);
      check("t6_result", {cout2, sum2}, exp2);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one external single-bit `Full_Adder` instance across a WIDTH-bit addition.
- Latches two operands and a carry-in on `start`, then presents one bit pair per cycle to the full adder, LSB first.
- Captures each sum bit and feeds the carry back through a flip-flop, then reports the result with a one-cycle `done` pulse.
- Sits between a requesting block and the `Full_Adder` datapath cell; the `fa_*` ports wire straight to that cell at the parent level.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on the rising edge, honoured only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the edge that accepts start.
- b  input  WIDTH  operand B; sampled on the edge that accepts start.
- cin  input  1  carry-in; sampled on the edge that accepts start.
- fa_d1  output  1  bit to Full_Adder D1.
- fa_d2  output  1  bit to Full_Adder D2.
- fa_cin  output  1  bit to Full_Adder Cin.
- fa_sum  input  1  from Full_Adder Sum_out; combinational function of fa_d1/fa_d2/fa_cin.
- fa_cout  input  1  from Full_Adder Cout.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high while in DONE.
- sum  output  WIDTH  last completed result, registered.
- cout  output  1  last completed carry-out, registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal a_sh, b_sh, sum_sh, carry and bit counter all cleared.
  - Reset has priority over every other event, including mid-RUN: the operation is aborted, and sum/cout are cleared rather than left partial.
- States: IDLE, RUN, DONE.
- IDLE:
  - fa_d1=fa_d2=fa_cin=0.
  - start=1 at an edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - fa_d1=a_sh[0], fa_d2=b_sh[0], fa_cin=carry (combinational from registers, so they are stable for the whole cycle).
  - Each edge:
    - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}
    - carry <= fa_cout
    - a_sh and b_sh shift right by one
    - cnt <= cnt+1
  - When cnt==WIDTH-1 at the edge: sum <= {fa_sum, sum_sh[WIDTH-1:1]}, cout <= fa_cout, go to DONE.
  - start is ignored in RUN; operands changing on a/b/cin have no effect.
- DONE:
  - done=1, busy=0, fa_* = 0.
  - Next edge with start=1: accept the new operation exactly as in IDLE and go to RUN (back-to-back operation).
  - Next edge with start=0: go to IDLE.
- Latency:
  - start accepted at edge E0; RUN occupies cycles E0..E(WIDTH), processing bits 0..WIDTH-1.
  - done is high in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after acceptance.
  - Throughput is one operation per WIDTH+1 cycles.
- Result holding:
  - sum/cout change only on entry to DONE or on reset.
  - They hold their value through IDLE and through a subsequent RUN until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH); the counter never wraps within a run because the exit happens at WIDTH-1.

Test Plan:
1. WIDTH=8; a=8'h5A, b=8'h3C, cin=0, 1-cycle start. Required: busy high 8 cycles; done high exactly on cycle 9 after acceptance; sum=8'h96, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
3. Start with a=8'h11, b=8'h22; pulse start again with a=8'hAA at cycle 3 of RUN. Required: second start ignored; sum=8'h33; no extra done pulse.
4. Start with a=8'hF0, b=8'h0F; assert rst at cycle 4 of RUN. Required: next cycle busy=0, done=0, sum=0, cout=0, fa_* = 0; then a new start (a=1, b=1) yields sum=8'h02.
5. Hold start high continuously with new operands presented in each DONE cycle. Required: operations chain with one DONE cycle between RUNs; each result correct; done pulses every 9 cycles.
6. WIDTH=2 exhaustive: all 32 combinations of a, b, cin. Required: {cout,sum} == a+b+cin for every case, checked against a behavioural model.
